// File: rtl/board_move_ctrl_pkg.sv
// Shared definitions for the 2048 board controller: tile geometry,
// move direction codes, FSM state encodings and the line-to-cell
// mapping used when a move walks the board one line at a time.
package board_move_ctrl_pkg;

    localparam int TILE_W  = 4;
    localparam int N_TILES = 16;
    localparam int BOARD_W = TILE_W * N_TILES;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_SPAWN  = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_STATUS = 3'd3;
    localparam logic [2:0] ST_IDLE   = 3'd4;
    localparam logic [2:0] ST_LINE   = 3'd5;
    localparam logic [2:0] ST_CHECK  = 3'd6;

    // Tile index: row 0 is the top row, col 0 the leftmost column.
    function automatic logic [3:0] tile_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Cell of element j in line k. Element 0 is the edge the tiles slide toward.
    function automatic logic [3:0] line_cell(input dir_e dir, input logic [1:0] k,
                                             input logic [1:0] j);
        logic [3:0] idx;
        case (dir)
            DIR_LEFT:  idx = tile_idx(k, j);
            DIR_RIGHT: idx = tile_idx(k, 2'd3 - j);
            DIR_UP:    idx = tile_idx(j, k);
            default:   idx = tile_idx(2'd3 - j, k);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/board_move_ctrl_if.sv
// Bus between the board controller and its environment (input decoder,
// LFSR, renderer timing and the VGA grid renderer).
//  vblank     : renderer outside active rows; commits only happen then
//  rand_val   : free-running LFSR value used for tile spawning
//  move_*     : move request handshake (valid held until ready)
//  load_*     : board preload, taken in IDLE
//  vals       : displayed board, tile idx at vals[4*idx +: 4]
//  busy/done/moved/win/lose : controller status
// master = requester side, slave = controller side.
interface board_move_ctrl_if;
    import board_move_ctrl_pkg::*;

    logic                 vblank;
    logic [15:0]          rand_val;
    logic                 move_valid;
    logic [1:0]           move_dir;
    logic                 move_ready;
    logic                 load_en;
    logic [BOARD_W-1:0]   load_vals;
    logic [BOARD_W-1:0]   vals;
    logic                 busy;
    logic                 done;
    logic                 moved;
    logic                 win;
    logic                 lose;

    modport master (
        output vblank, rand_val, move_valid, move_dir, load_en, load_vals,
        input  move_ready, vals, busy, done, moved, win, lose
    );

    modport slave (
        input  vblank, rand_val, move_valid, move_dir, load_en, load_vals,
        output move_ready, vals, busy, done, moved, win, lose
    );

endinterface

// File: rtl/board_move_ctrl_slide_merge_line.sv
// Combinational slide/merge of one 4-tile line.
//  line_in  : tiles e0..e3, e0 at [3:0] is the edge tiles slide toward
//  line_out : line after compaction and merging
//  changed  : line_out differs from line_in
// Non-zero tiles are compacted toward e0, then equal neighbours are merged
// scanning from e0; a tile merges at most once and exponent 15 never merges.
module slide_merge_line
    import board_move_ctrl_pkg::*;
(
    input  logic [4*TILE_W-1:0] line_in,
    output logic [4*TILE_W-1:0] line_out,
    output logic                changed
);

    // Five slots so the merge scan can always look one past the last tile.
    logic [TILE_W-1:0] comp_t   [5];
    logic [TILE_W-1:0] merged_t [4];
    logic [2:0]        n_fill;
    logic [2:0]        n_out;
    logic              skip;

    always_comb begin
        for (int i = 0; i < 5; i++) comp_t[i] = '0;
        for (int i = 0; i < 4; i++) merged_t[i] = '0;
        n_fill = '0;
        n_out  = '0;
        skip   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (line_in[TILE_W*i +: TILE_W] != '0) begin
                comp_t[n_fill] = line_in[TILE_W*i +: TILE_W];
                n_fill = n_fill + 3'd1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                // Second tile of a merged pair is consumed.
                skip = 1'b0;
            end else if (comp_t[i] != '0) begin
                if (comp_t[i+1] == comp_t[i] && comp_t[i] != 4'hF) begin
                    merged_t[n_out[1:0]] = comp_t[i] + 4'd1;
                    skip = 1'b1;
                end else begin
                    merged_t[n_out[1:0]] = comp_t[i];
                end
                n_out = n_out + 3'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            assign line_out[TILE_W*gi +: TILE_W] = merged_t[gi];
        end
    endgenerate

    assign changed = (line_out != line_in);

endmodule

// File: rtl/board_move_ctrl.sv
// 2048 board controller. Owns the 16-tile working board, sequences a move
// one line per cycle, spawns a new tile, and copies the working board to
// the displayed board only while vblank is high so frames never tear.
//  dclk  : pixel clock, sole clock
//  clr_n : synchronous reset, active low
//  bus   : slave side of board_move_ctrl_if (move/load requests, board and status)
module board_move_ctrl
    import board_move_ctrl_pkg::*;
#(
    parameter logic [3:0]  WIN_EXP    = 4'd11,
    parameter logic [3:0]  FOUR_MASK  = 4'hF,
    parameter int unsigned INIT_TILES = 2
) (
    input  logic             dclk,
    input  logic             clr_n,
    board_move_ctrl_if.slave bus
);

    logic [2:0]         state_q, state_d;
    logic [BOARD_W-1:0] work_q, work_d;
    logic [BOARD_W-1:0] vals_q, vals_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               done_q, done_d;
    logic               moved_q, moved_d;
    dir_e               dir_q, dir_d;
    logic [1:0]         k_q, k_d;
    logic               changed_q, changed_d;
    logic               from_move_q, from_move_d;
    logic [4:0]         spawn_left_q, spawn_left_d;
    logic [3:0]         scan_q, scan_d;
    logic [3:0]         start_q, start_d;
    logic [3:0]         sval_q, sval_d;

    // Line datapath: gather line k in direction dir_q, slide/merge it.
    logic [4*TILE_W-1:0] line_in;
    logic [4*TILE_W-1:0] line_out;
    logic                line_changed;
    logic [3:0]          cell_idx [4];

    // Board status flags over the working board.
    logic [N_TILES-1:0]  tile_zero;
    logic [N_TILES-1:0]  tile_win;
    logic [N_TILES-1:0]  pair_h;
    logic [N_TILES-1:0]  pair_v;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_line
            assign cell_idx[gi] = line_cell(dir_q, k_q, 2'(gi));
            assign line_in[TILE_W*gi +: TILE_W] = work_q[{cell_idx[gi], 2'b00} +: TILE_W];
        end

        for (gi = 0; gi < N_TILES; gi++) begin : g_tile
            logic [TILE_W-1:0] t;
            assign t = work_q[TILE_W*gi +: TILE_W];
            assign tile_zero[gi] = (t == '0);
            assign tile_win[gi]  = (t >= WIN_EXP);
            if ((gi % 4) != 3) begin : g_h
                assign pair_h[gi] = (t == work_q[TILE_W*(gi+1) +: TILE_W]);
            end else begin : g_hn
                assign pair_h[gi] = 1'b0;
            end
            if (gi < 12) begin : g_v
                assign pair_v[gi] = (t == work_q[TILE_W*(gi+4) +: TILE_W]);
            end else begin : g_vn
                assign pair_v[gi] = 1'b0;
            end
        end
    endgenerate

    slide_merge_line u_line (
        .line_in  (line_in),
        .line_out (line_out),
        .changed  (line_changed)
    );

    // Spawn scan: the first cycle of a scan takes start cell and value
    // straight from rand_val and latches them for the rest of the scan.
    logic [3:0] spawn_idx;
    logic [3:0] spawn_val;
    logic       spawn_hit;

    assign spawn_idx = (scan_q == 4'd0) ? bus.rand_val[3:0] : start_q + scan_q;
    assign spawn_val = (scan_q != 4'd0) ? sval_q :
                       (((bus.rand_val[7:4] & FOUR_MASK) == 4'd0) ? 4'd2 : 4'd1);
    assign spawn_hit = (work_q[{spawn_idx, 2'b00} +: TILE_W] == '0);

    logic unused_rand_hi;
    assign unused_rand_hi = ^bus.rand_val[15:8];

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        vals_d       = vals_q;
        win_d        = win_q;
        lose_d       = lose_q;
        done_d       = 1'b0;
        moved_d      = 1'b0;
        dir_d        = dir_q;
        k_d          = k_q;
        changed_d    = changed_q;
        from_move_d  = from_move_q;
        spawn_left_d = spawn_left_q;
        scan_d       = scan_q;
        start_d      = start_q;
        sval_d       = sval_q;

        case (state_q)
            ST_INIT: begin
                scan_d  = 4'd0;
                state_d = (spawn_left_q == 5'd0) ? ST_COMMIT : ST_SPAWN;
            end

            ST_IDLE: begin
                // Load is taken even while lost: it is the way out of a lost game.
                if (bus.load_en) begin
                    work_d      = bus.load_vals;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    from_move_d = 1'b0;
                    state_d     = ST_COMMIT;
                end else if (bus.move_valid && !lose_q) begin
                    dir_d       = dir_e'(bus.move_dir);
                    k_d         = 2'd0;
                    changed_d   = 1'b0;
                    state_d     = ST_LINE;
                end
            end

            ST_LINE: begin
                for (int j = 0; j < 4; j++) begin
                    work_d[{cell_idx[j], 2'b00} +: TILE_W] = line_out[TILE_W*j +: TILE_W];
                end
                changed_d = changed_q | line_changed;
                k_d       = k_q + 2'd1;
                if (k_q == 2'd3) state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (changed_q) begin
                    from_move_d  = 1'b1;
                    spawn_left_d = 5'd1;
                    scan_d       = 4'd0;
                    state_d      = ST_SPAWN;
                end else begin
                    done_d  = 1'b1;
                    moved_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_SPAWN: begin
                if (scan_q == 4'd0) begin
                    start_d = bus.rand_val[3:0];
                    sval_d  = spawn_val;
                end
                if (spawn_hit) begin
                    work_d[{spawn_idx, 2'b00} +: TILE_W] = spawn_val;
                end
                if (spawn_hit || scan_q == 4'd15) begin
                    spawn_left_d = spawn_left_q - 5'd1;
                    scan_d       = 4'd0;
                    state_d      = (spawn_left_q == 5'd1) ? ST_COMMIT : ST_SPAWN;
                end else begin
                    scan_d = scan_q + 4'd1;
                end
            end

            ST_COMMIT: begin
                if (bus.vblank) begin
                    vals_d  = work_q;
                    state_d = ST_STATUS;
                end
            end

            ST_STATUS: begin
                win_d  = win_q | (|tile_win);
                lose_d = !(|tile_zero) && !(|pair_h) && !(|pair_v);
                if (from_move_q) begin
                    done_d  = 1'b1;
                    moved_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            state_q      <= ST_INIT;
            work_q       <= '0;
            vals_q       <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            done_q       <= 1'b0;
            moved_q      <= 1'b0;
            dir_q        <= DIR_UP;
            k_q          <= 2'd0;
            changed_q    <= 1'b0;
            from_move_q  <= 1'b0;
            spawn_left_q <= 5'(INIT_TILES);
            scan_q       <= 4'd0;
            start_q      <= 4'd0;
            sval_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            vals_q       <= vals_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            done_q       <= done_d;
            moved_q      <= moved_d;
            dir_q        <= dir_d;
            k_q          <= k_d;
            changed_q    <= changed_d;
            from_move_q  <= from_move_d;
            spawn_left_q <= spawn_left_d;
            scan_q       <= scan_d;
            start_q      <= start_d;
            sval_q       <= sval_d;
        end
    end

    assign bus.vals       = vals_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.move_ready = (state_q == ST_IDLE) && !lose_q;
    assign bus.done       = done_q;
    assign bus.moved      = moved_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Scoreboard bench for board_move_ctrl: stimulus pushes the expected
// outcome of each load/move/reset, a monitor pops it when the controller
// drops busy and compares board and status.
module tb_board_move_ctrl;
    import board_move_ctrl_pkg::*;

    localparam logic [3:0] WIN_EXP   = 4'd11;
    localparam logic [3:0] FOUR_MASK = 4'hF;
    localparam int         N_INIT    = 2;

    logic dclk  = 1'b0;
    logic clr_n = 1'b0;

    board_move_ctrl_if bus ();

    board_move_ctrl #(
        .WIN_EXP    (WIN_EXP),
        .FOUR_MASK  (FOUR_MASK),
        .INIT_TILES (N_INIT)
    ) dut (
        .dclk  (dclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic [63:0] vals;
        logic        done;
        logic        moved;
        logic        win;
        logic        lose;
    } exp_t;

    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_vals = '0;
    logic        m_win  = 1'b0;
    logic        m_lose = 1'b0;
    bit          vb_force_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int tile_at(input logic [63:0] b, input int idx);
        return int'(b[4*idx +: 4]);
    endfunction

    function automatic int m_cell(input int dir, input int k, input int j);
        case (dir)
            0:       return j * 4 + k;
            1:       return (3 - j) * 4 + k;
            2:       return k * 4 + j;
            default: return k * 4 + (3 - j);
        endcase
    endfunction

    function automatic void model_move(input logic [63:0] b, input int dir,
                                       output logic [63:0] nb, output bit chg);
        int src [$];
        int res [$];
        nb = b;
        for (int k = 0; k < 4; k++) begin
            src.delete();
            res.delete();
            for (int j = 0; j < 4; j++)
                if (tile_at(b, m_cell(dir, k, j)) != 0) src.push_back(tile_at(b, m_cell(dir, k, j)));
            while (src.size() > 0) begin
                if (src.size() >= 2 && src[0] == src[1] && src[0] != 15) begin
                    res.push_back(src[0] + 1);
                    void'(src.pop_front());
                    void'(src.pop_front());
                end else begin
                    res.push_back(src.pop_front());
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int j = 0; j < 4; j++) nb[4*m_cell(dir, k, j) +: 4] = 4'(res[j]);
        end
        chg = (nb != b);
    endfunction

    function automatic logic [63:0] model_spawn(input logic [63:0] b, input logic [15:0] r);
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = (int'(r[3:0]) + i) % 16;
            if (tile_at(b, idx) == 0) begin
                b[4*idx +: 4] = ((r[7:4] & FOUR_MASK) == 4'd0) ? 4'd2 : 4'd1;
                return b;
            end
        end
        return b;
    endfunction

    function automatic logic m_any_win(input logic [63:0] b);
        for (int i = 0; i < 16; i++) if (tile_at(b, i) >= int'(WIN_EXP)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_is_lose(input logic [63:0] b);
        for (int i = 0; i < 16; i++) if (tile_at(b, i) == 0) return 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && tile_at(b, r*4+c) == tile_at(b, r*4+c+1)) return 1'b0;
                if (r < 3 && tile_at(b, r*4+c) == tile_at(b, (r+1)*4+c)) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] rand_board();
        logic [63:0] b;
        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            b[4*i +: 4] = (r < 4) ? 4'd0 : 4'(r - 3);
        end
        return b;
    endfunction

    // ---------------- vblank generator ----------------
    initial begin
        bus.vblank = 1'b0;
        forever begin
            repeat (100) @(negedge dclk);
            bus.vblank = vb_force_low ? 1'b0 : ~bus.vblank;
        end
    end

    // ---------------- monitor ----------------
    logic        vb_s   = 1'b0;
    logic        rstn_s = 1'b0;
    logic        busy_prev;
    logic [63:0] vals_prev;

    always @(posedge dclk) begin
        vb_s   <= bus.vblank;
        rstn_s <= clr_n;
    end

    initial begin
        exp_t e;
        bit   fall;
        forever begin
            @(negedge dclk);
            fall = (busy_prev === 1'b1) && (bus.busy === 1'b0);
            if (fall) begin
                if (exp_q.size() == 0) begin
                    check("idle_without_request", 64'(bus.busy), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("vals",       bus.vals,              e.vals);
                    check("done",       64'(bus.done),         64'(e.done));
                    check("moved",      64'(bus.moved),        64'(e.moved));
                    check("win",        64'(bus.win),          64'(e.win));
                    check("lose",       64'(bus.lose),         64'(e.lose));
                    check("move_ready", 64'(bus.move_ready),   64'(!e.lose));
                end
            end else if (bus.done === 1'b1) begin
                check("stray_done", 64'(bus.done), 64'(0));
            end
            if (rstn_s === 1'b1 && bus.vals !== vals_prev)
                check("vals_change_outside_vblank", 64'(vb_s), 64'(1));
            busy_prev = bus.busy;
            vals_prev = bus.vals;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge dclk);
            t++;
        end
        check({tag, "_timeout"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic do_reset(input logic [15:0] r, input string tag);
        exp_t e;
        @(negedge dclk);
        clr_n          = 1'b0;
        bus.rand_val   = r;
        bus.move_valid = 1'b0;
        bus.load_en    = 1'b0;
        @(negedge dclk);
        @(negedge dclk);
        exp_q.delete();
        check("rst_vals",  bus.vals,              64'(0));
        check("rst_busy",  64'(bus.busy),         64'(1));
        check("rst_ready", 64'(bus.move_ready),   64'(0));
        check("rst_win",   64'(bus.win),          64'(0));
        check("rst_lose",  64'(bus.lose),         64'(0));
        check("rst_done",  64'(bus.done),         64'(0));
        check("rst_moved", 64'(bus.moved),        64'(0));
        m_vals = '0;
        for (int i = 0; i < N_INIT; i++) m_vals = model_spawn(m_vals, r);
        m_win  = m_any_win(m_vals);
        m_lose = m_is_lose(m_vals);
        e.vals = m_vals; e.done = 1'b0; e.moved = 1'b0; e.win = m_win; e.lose = m_lose;
        exp_q.push_back(e);
        clr_n = 1'b1;
        wait_drain(tag);
        $display("reset %s rand=%h -> vals=%h", tag, r, bus.vals);
    endtask

    task automatic do_load(input logic [63:0] v, input string tag);
        exp_t e;
        m_vals = v;
        m_win  = m_any_win(v);
        m_lose = m_is_lose(v);
        e.vals = v; e.done = 1'b0; e.moved = 1'b0; e.win = m_win; e.lose = m_lose;
        exp_q.push_back(e);
        @(negedge dclk);
        bus.load_vals = v;
        bus.load_en   = 1'b1;
        @(negedge dclk);
        bus.load_en   = 1'b0;
        wait_drain(tag);
        $display("load %s vals=%h win=%0d lose=%0d", tag, bus.vals, bus.win, bus.lose);
    endtask

    task automatic do_move(input int dir, input string tag);
        exp_t        e;
        logic [63:0] nb;
        bit          chg;
        int          t;
        model_move(m_vals, dir, nb, chg);
        if (chg) begin
            nb     = model_spawn(nb, bus.rand_val);
            m_vals = nb;
            m_win  = m_win | m_any_win(nb);
            m_lose = m_is_lose(nb);
        end
        e.vals = m_vals; e.done = 1'b1; e.moved = chg; e.win = m_win; e.lose = m_lose;
        exp_q.push_back(e);
        @(negedge dclk);
        bus.move_dir   = 2'(dir);
        bus.move_valid = 1'b1;
        t = 0;
        do begin
            @(negedge dclk);
            t++;
        end while (bus.busy !== 1'b1 && t < 50);
        bus.move_valid = 1'b0;
        check({tag, "_accept"}, 64'(bus.busy), 64'(1));
        wait_drain(tag);
        $display("move %s dir=%0d rand=%h -> vals=%h moved=%0d win=%0d lose=%0d",
                 tag, dir, bus.rand_val, bus.vals, bus.moved, bus.win, bus.lose);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] frozen;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.load_en    = 1'b0;
        bus.load_vals  = '0;
        bus.rand_val   = 16'h0015;

        // Spawn value 2 (exp 1) at idx5 then idx6.
        do_reset(16'h0015, "init");
        check("init_board", bus.vals, 64'h0000_0000_0110_0000);

        bus.rand_val = 16'h0005;
        do_load(64'h2211, "row0_2211");
        do_move(2, "left_2211");
        do_load(64'h0001, "idx0_only");
        do_move(2, "left_nochange");
        do_load(64'h1111, "row0_1111");
        do_move(3, "right_1111");
        do_load(64'h0111, "row0_0111");
        do_move(2, "left_0111");
        do_load(64'h00FF, "row0_ff");
        do_move(2, "left_ff_nomerge");
        do_load(64'h00AA, "row0_aa");
        do_move(2, "left_aa_win");
        do_move(1, "down_after_win");

        // Lost board: move requests are not taken.
        do_load(64'h1212_2121_1212_2121, "checker");
        @(negedge dclk);
        bus.move_dir   = 2'd2;
        bus.move_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge dclk);
            if (i % 20 == 0) begin
                check("lose_busy",  64'(bus.busy),       64'(0));
                check("lose_ready", 64'(bus.move_ready), 64'(0));
                check("lose_vals",  bus.vals,            m_vals);
            end
        end
        bus.move_valid = 1'b0;
        do_load(64'h0000_0000_0000_0012, "recover");

        // Renderer never leaves active video: the move stalls in commit.
        @(negedge dclk);
        vb_force_low = 1'b1;
        bus.vblank   = 1'b0;
        frozen       = bus.vals;
        bus.move_dir   = 2'd3;
        bus.move_valid = 1'b1;
        @(negedge dclk);
        bus.move_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge dclk);
            if (i % 100 == 99) begin
                check("stall_busy", 64'(bus.busy), 64'(1));
                check("stall_vals", bus.vals,      frozen);
            end
        end
        vb_force_low = 1'b0;
        do_reset(16'h0015, "reset_in_commit");

        // Randomised play.
        for (int i = 0; i < 30; i++) begin
            if (m_lose || (i % 6) == 0) begin
                do_load(rand_board(), "rnd_load");
            end else begin
                @(negedge dclk);
                bus.rand_val = 16'($urandom);
                do_move($urandom_range(0, 3), "rnd_move");
            end
        end

        repeat (5) @(negedge dclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
